// File: rtl/javk_pkg.sv
// javk_pkg: shared constants and types for the JAVK CPU front end.
//   JAVK_ADDR_W / JAVK_DATA_W : address and bus data widths
//   JAVK_RESET_PC             : default fetch address after reset
//   fetch_state_e, ST_*       : fetch FSM state encoding
//   fetch_entry_t             : one prefetch-queue entry {pc, byte}
package javk_pkg;

  localparam int JAVK_ADDR_W = 16;
  localparam int JAVK_DATA_W = 8;
  localparam logic [JAVK_ADDR_W-1:0] JAVK_RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

  // Plain-vector state constants for code that keeps state in logic regs.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic [JAVK_ADDR_W-1:0] pc;
    logic [JAVK_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/javk_fetch_queue.sv
// javk_fetch_queue: synchronous FIFO of {pc, byte} prefetch entries.
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : drop all entries (wins over push/pop)
//   push_i        : write push_entry_i at the tail
//   pop_i         : advance the head (caller guarantees non-empty)
//   count_o       : number of valid entries
//   head_o        : head entry, straight from the storage registers
module javk_fetch_queue
  import javk_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [15:0]     RESET_PC = JAVK_RESET_PC,
  localparam int             AW       = $clog2(DEPTH),
  localparam int             CW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  push_entry_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;

  // Pointers are exactly AW bits wide so they wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Entries are reset so the head reads {RESET_PC, 00} out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: RESET_PC, data: '0};
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The upstream credit check makes this unreachable; catch it if it breaks.
  always_ff @(posedge clk) begin
    if (!rst && !clr_i) begin
      assert (!(push_i && !pop_i && (count_q == CW'(DEPTH))))
        else $error("javk_fetch_queue: push into full queue");
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/javk_fetch.sv
// javk_fetch: JAVK instruction fetch unit. Issues byte reads on the 8-bit
// memory bus, buffers the returned bytes and hands them to the core one at
// a time.
//   clk, rst     : clock, synchronous active-high reset
//   bus_busy     : core owns the bus; no fetch read this cycle
//   rd_en        : read strobe (combinational)
//   rd_addr      : read address (combinational, = fetch PC)
//   rd_data      : read data, one cycle after the rd_en cycle
//   redirect     : flush and restart at redirect_pc
//   redirect_pc  : new fetch address
//   out_valid    : head byte available
//   out_ready    : core takes the head byte
//   out_byte     : head byte
//   out_pc       : address of the head byte
module javk_fetch
  import javk_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = JAVK_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_busy,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [15:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [0:0]    state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   iss_pc_q;     // address of the read currently on the bus
  logic          inflight_q;
  logic          drop_q;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          issue, push, pop;
  fetch_entry_t  push_entry, head;

  // Every queued byte and every outstanding read holds one slot, so the
  // queue can never be pushed while full.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue       = !rst && (state_q == ST_RUN) && !bus_busy && !redirect &&
                       (credit_used < (CW+1)'(DEPTH));

  assign rd_en   = issue;
  assign rd_addr = fetch_pc_q;

  // Redirect wins: the byte arriving in the redirect cycle is stale.
  assign push       = inflight_q && !drop_q && !redirect;
  assign push_entry = '{pc: iss_pc_q, data: rd_data};

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect;
  assign out_byte  = head.data;
  assign out_pc    = head.pc;

  always_comb begin
    // FLUSH lasts one cycle; a redirect (re)enters it from either state.
    state_d    = redirect ? ST_FLUSH : ST_RUN;
    fetch_pc_d = fetch_pc_q;
    if (redirect)   fetch_pc_d = redirect_pc;
    else if (issue) fetch_pc_d = fetch_pc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      iss_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) iss_pc_q <= fetch_pc_q;
      // Mark a read caught by a redirect as stale; nothing is issued in the
      // redirect cycle, so the mark only ever lives for the FLUSH cycle.
      drop_q     <= redirect && inflight_q;
    end
  end

  javk_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (redirect),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (push_entry),
    .count_o      (count),
    .head_o       (head)
  );

endmodule
